// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for the shared 64-bit ALU.
// Accepts one operation at a time, runs it through the external combinational
// ALU for a single cycle, registers result/flags and returns them to the
// requester that issued the operation.
//
// Handshake semantics (all channels): a transfer happens on a rising edge
// where valid and ready are both high. A requester drives valid and holds its
// payload until it sees ready. Ready is never a function of anything other
// than current state and valids, so there is no combinational path from
// ready back into valid. Response payload (resp_f/resp_status/resp_err)
// is registered and stays constant while respN_valid is high.
module alu_arbiter #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   // requester 0 operation channel
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [3:0]   req0_fs,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   // requester 1 operation channel
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [3:0]   req1_fs,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   // response channels (shared payload)
   output logic         resp0_valid,
   input  logic         resp0_ready,
   output logic         resp1_valid,
   input  logic         resp1_ready,
   output logic [W-1:0] resp_f,
   output logic [3:0]   resp_status,
   output logic         resp_err,
   output logic         busy,
   // external ALU
   output logic [3:0]   alu_fs,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   input  logic [W-1:0] alu_f,
   input  logic [3:0]   alu_status,
   // FSM state for observation
   output logic [1:0]   dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_next;

   logic           r_prio;        // requester favoured when both are valid
   logic           r_owner;       // requester that owns the in-flight op
   logic [3:0]     r_fs;
   logic [W-1:0]   r_a;
   logic [W-1:0]   r_b;
   logic [W-1:0]   r_resp_f;
   logic [3:0]     r_resp_status;
   logic           r_resp_err;

   logic           w_grant;       // requester selected by arbitration
   logic           w_accept;      // operation handshake this cycle
   logic           w_resp_hs;     // response handshake this cycle
   logic [3:0]     w_acc_fs;
   logic [W-1:0]   w_acc_a;
   logic [W-1:0]   w_acc_b;
   logic           w_acc_legal;

   // Only the function codes the ALU actually implements are accepted.
   function automatic logic f_legal(input logic [3:0] fs);
      case (fs)
         4'b0000, 4'b0001, 4'b0010,
         4'b0110, 4'b0111, 4'b1100: f_legal = 1'b1;
         default:                   f_legal = 1'b0;
      endcase
   endfunction

   // Arbitration and payload selection for the granted requester.
   always_comb begin
      w_grant = 1'b0;
      if (req0_valid && req1_valid) begin
         w_grant = r_prio;
      end else if (req1_valid) begin
         w_grant = 1'b1;
      end
      w_acc_fs    = w_grant ? req1_fs : req0_fs;
      w_acc_a     = w_grant ? req1_a  : req0_a;
      w_acc_b     = w_grant ? req1_b  : req0_b;
      w_acc_legal = f_legal(w_acc_fs);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next-state and handshake outputs.
   always_comb begin
      w_state_next = r_state;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      resp0_valid  = 1'b0;
      resp1_valid  = 1'b0;
      w_accept     = 1'b0;
      w_resp_hs    = 1'b0;
      busy         = 1'b1;
      case (r_state)
         S_IDLE: begin
            busy       = 1'b0;
            req0_ready = req0_valid && !w_grant;
            req1_ready = req1_valid &&  w_grant;
            w_accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
            if (w_accept) begin
               // Illegal codes skip the ALU and answer immediately with an error.
               w_state_next = w_acc_legal ? S_EXEC : S_RESP;
            end
         end
         S_EXEC: begin
            w_state_next = S_RESP;
         end
         S_RESP: begin
            resp0_valid = !r_owner;
            resp1_valid =  r_owner;
            w_resp_hs   = r_owner ? resp1_ready : resp0_ready;
            if (w_resp_hs) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Operand capture on acceptance, result capture in EXEC, fairness update
   // on response completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prio        <= 1'b0;
         r_owner       <= 1'b0;
         r_fs          <= '0;
         r_a           <= '0;
         r_b           <= '0;
         r_resp_f      <= '0;
         r_resp_status <= '0;
         r_resp_err    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_fs    <= w_acc_fs;
            r_a     <= w_acc_a;
            r_b     <= w_acc_b;
            r_owner <= w_grant;
            if (!w_acc_legal) begin
               r_resp_f      <= '0;
               r_resp_status <= '0;
               r_resp_err    <= 1'b1;
            end
         end
         if (r_state == S_EXEC) begin
            r_resp_f      <= alu_f;
            r_resp_status <= alu_status;
            r_resp_err    <= 1'b0;
         end
         if (w_resp_hs) begin
            // The requester just served loses priority for the next contest.
            r_prio <= ~r_owner;
         end
      end
   end

   // The ALU sees the operand registers at all times; they only change on
   // acceptance, so the ALU inputs are quiet outside of new operations.
   assign alu_fs      = r_fs;
   assign alu_a       = r_a;
   assign alu_b       = r_b;
   assign resp_f      = r_resp_f;
   assign resp_status = r_resp_status;
   assign resp_err    = r_resp_err;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a behavioural ALU model attached.
module tb_alu_arbiter;

   localparam int W = 64;

   logic         clk;
   logic         rst;
   logic         req0_valid, req0_ready;
   logic [3:0]   req0_fs;
   logic [W-1:0] req0_a, req0_b;
   logic         req1_valid, req1_ready;
   logic [3:0]   req1_fs;
   logic [W-1:0] req1_a, req1_b;
   logic         resp0_valid, resp0_ready;
   logic         resp1_valid, resp1_ready;
   logic [W-1:0] resp_f;
   logic [3:0]   resp_status;
   logic         resp_err;
   logic         busy;
   logic [3:0]   alu_fs;
   logic [W-1:0] alu_a, alu_b, alu_f;
   logic [3:0]   alu_status;
   logic [1:0]   dbg_state;

   int total;
   int bad;

   alu_arbiter #(.W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_fs     (req0_fs),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_fs     (req1_fs),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .resp0_valid (resp0_valid),
      .resp0_ready (resp0_ready),
      .resp1_valid (resp1_valid),
      .resp1_ready (resp1_ready),
      .resp_f      (resp_f),
      .resp_status (resp_status),
      .resp_err    (resp_err),
      .busy        (busy),
      .alu_fs      (alu_fs),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_f       (alu_f),
      .alu_status  (alu_status),
      .dbg_state   (dbg_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: and, or, add, sub, slt, nor; flags {cout, z, v, n}.
   logic [W:0] m_sum;
   logic       m_cout, m_v;
   always_comb begin
      m_sum  = '0;
      m_cout = 1'b0;
      m_v    = 1'b0;
      alu_f  = '0;
      case (alu_fs)
         4'b0000: alu_f = alu_a & alu_b;
         4'b0001: alu_f = alu_a | alu_b;
         4'b0010: begin
            m_sum  = {1'b0, alu_a} + {1'b0, alu_b};
            alu_f  = m_sum[W-1:0];
            m_cout = m_sum[W];
            m_v    = (alu_a[W-1] == alu_b[W-1]) && (alu_f[W-1] != alu_a[W-1]);
         end
         4'b0110: begin
            m_sum  = {1'b0, alu_a} + {1'b0, ~alu_b} + {{W{1'b0}}, 1'b1};
            alu_f  = m_sum[W-1:0];
            m_cout = m_sum[W];
            m_v    = (alu_a[W-1] != alu_b[W-1]) && (alu_f[W-1] != alu_a[W-1]);
         end
         4'b0111: alu_f = {{(W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
         4'b1100: alu_f = ~(alu_a | alu_b);
         default: alu_f = '0;
      endcase
      alu_status = {m_cout, (alu_f == '0), m_v, alu_f[W-1]};
   end

   // One comparison point.
   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and checks happen 2ns after the edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      req0_valid  = 1'b0; req0_fs = '0; req0_a = '0; req0_b = '0;
      req1_valid  = 1'b0; req1_fs = '0; req1_a = '0; req1_b = '0;
      resp0_ready = 1'b0; resp1_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      idle_inputs();

      // ---------------- reset state
      do_reset();
      #1;
      chk("rst_busy",   {63'd0, busy}, 64'd0);
      chk("rst_rdy0",   {63'd0, req0_ready}, 64'd0);
      chk("rst_rdy1",   {63'd0, req1_ready}, 64'd0);
      chk("rst_rv0",    {63'd0, resp0_valid}, 64'd0);
      chk("rst_rv1",    {63'd0, resp1_valid}, 64'd0);
      chk("rst_alu_fs", {60'd0, alu_fs}, 64'd0);
      chk("rst_alu_a",  alu_a, 64'd0);
      chk("rst_resp_f", resp_f, 64'd0);
      chk("rst_err",    {63'd0, resp_err}, 64'd0);

      // ---------------- single op: add 5+7 on req0
      req0_valid = 1'b1; req0_fs = 4'b0010; req0_a = 64'd5; req0_b = 64'd7;
      #1;
      chk("s_rdy0", {63'd0, req0_ready}, 64'd1);
      chk("s_rdy1", {63'd0, req1_ready}, 64'd0);
      cyc();                                   // EXEC
      req0_valid = 1'b0; req0_a = 64'd99;      // no effect after acceptance
      #1;
      chk("s_exec_busy", {63'd0, busy}, 64'd1);
      chk("s_exec_fs",   {60'd0, alu_fs}, 64'd2);
      chk("s_exec_a",    alu_a, 64'd5);
      chk("s_exec_rv0",  {63'd0, resp0_valid}, 64'd0);
      cyc();                                   // RESP
      chk("s_rv0",    {63'd0, resp0_valid}, 64'd1);
      chk("s_rv1",    {63'd0, resp1_valid}, 64'd0);
      chk("s_f",      resp_f, 64'd12);
      chk("s_status", {60'd0, resp_status}, 64'd0);
      chk("s_err",    {63'd0, resp_err}, 64'd0);
      chk("s_hold_a", alu_a, 64'd5);
      resp0_ready = 1'b1;
      cyc();                                   // IDLE
      chk("s_done_busy", {63'd0, busy}, 64'd0);
      chk("s_done_rv0",  {63'd0, resp0_valid}, 64'd0);

      // ---------------- contention: both sub 10-3
      do_reset();
      req0_valid = 1'b1; req0_fs = 4'b0110; req0_a = 64'd10; req0_b = 64'd3;
      req1_valid = 1'b1; req1_fs = 4'b0110; req1_a = 64'd10; req1_b = 64'd3;
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      #1;
      chk("c_rdy0_first", {63'd0, req0_ready}, 64'd1);
      chk("c_rdy1_first", {63'd0, req1_ready}, 64'd0);
      cyc();                                   // EXEC owner 0
      cyc();                                   // RESP owner 0
      chk("c_rv0",    {63'd0, resp0_valid}, 64'd1);
      chk("c_rv1_0",  {63'd0, resp1_valid}, 64'd0);
      chk("c_f0",     resp_f, 64'd7);
      chk("c_st0",    {60'd0, resp_status}, 64'h8);
      cyc();                                   // IDLE, prio=1
      chk("c_rdy1_second", {63'd0, req1_ready}, 64'd1);
      chk("c_rdy0_second", {63'd0, req0_ready}, 64'd0);
      cyc();                                   // EXEC owner 1
      cyc();                                   // RESP owner 1
      chk("c_rv1",   {63'd0, resp1_valid}, 64'd1);
      chk("c_rv0_1", {63'd0, resp0_valid}, 64'd0);
      chk("c_f1",    resp_f, 64'd7);
      cyc();                                   // IDLE, prio=0
      chk("c_rdy0_third", {63'd0, req0_ready}, 64'd1);
      chk("c_rdy1_third", {63'd0, req1_ready}, 64'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;

      // ---------------- illegal fs on req1
      do_reset();
      req1_valid = 1'b1; req1_fs = 4'b1111; req1_a = 64'd9; req1_b = 64'd0;
      #1;
      chk("i_rdy1", {63'd0, req1_ready}, 64'd1);
      cyc();                                   // straight to RESP
      req1_valid = 1'b0;
      chk("i_state",  {62'd0, dbg_state}, 64'd2);
      chk("i_rv1",    {63'd0, resp1_valid}, 64'd1);
      chk("i_rv0",    {63'd0, resp0_valid}, 64'd0);
      chk("i_f",      resp_f, 64'd0);
      chk("i_status", {60'd0, resp_status}, 64'd0);
      chk("i_err",    {63'd0, resp_err}, 64'd1);
      resp1_ready = 1'b1;
      cyc();
      chk("i_done_busy", {63'd0, busy}, 64'd0);
      resp1_ready = 1'b0;

      // ---------------- back-pressure on resp0 while req1 waits
      do_reset();
      req0_valid = 1'b1; req0_fs = 4'b0010; req0_a = 64'd1; req0_b = 64'd2;
      req1_valid = 1'b1; req1_fs = 4'b0010; req1_a = 64'd3; req1_b = 64'd4;
      cyc();                                   // EXEC owner 0
      req0_valid = 1'b0;
      cyc();                                   // RESP, stalled
      for (int i = 0; i < 5; i++) begin
         chk("bp_rv0",    {63'd0, resp0_valid}, 64'd1);
         chk("bp_f",      resp_f, 64'd3);
         chk("bp_status", {60'd0, resp_status}, 64'd0);
         chk("bp_busy",   {63'd0, busy}, 64'd1);
         chk("bp_rdy1",   {63'd0, req1_ready}, 64'd0);
         cyc();
      end
      resp0_ready = 1'b1;
      cyc();                                   // IDLE
      chk("bp_rdy1_after", {63'd0, req1_ready}, 64'd1);
      resp0_ready = 1'b0; resp1_ready = 1'b1;
      cyc();                                   // EXEC owner 1
      req1_valid = 1'b0;
      cyc();                                   // RESP owner 1
      chk("bp_rv1", {63'd0, resp1_valid}, 64'd1);
      chk("bp_f1",  resp_f, 64'd7);
      cyc();
      resp1_ready = 1'b0;

      // ---------------- reset during EXEC
      do_reset();
      req0_valid = 1'b1; req0_fs = 4'b0000; req0_a = 64'hF0; req0_b = 64'h3C;
      resp0_ready = 1'b1;
      cyc();                                   // EXEC
      chk("r_in_exec", {62'd0, dbg_state}, 64'd1);
      rst = 1'b1; req0_valid = 1'b0;
      cyc();                                   // reset taken on this edge
      chk("r_busy",   {63'd0, busy}, 64'd0);
      chk("r_rv0",    {63'd0, resp0_valid}, 64'd0);
      chk("r_alu_a",  alu_a, 64'd0);
      chk("r_alu_fs", {60'd0, alu_fs}, 64'd0);
      chk("r_resp_f", resp_f, 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("r_no_rv0", {63'd0, resp0_valid}, 64'd0);
         chk("r_no_rv1", {63'd0, resp1_valid}, 64'd0);
      end
      resp0_ready = 1'b0;

      // ---------------- flag pass-through: nor 0,0
      do_reset();
      req0_valid = 1'b1; req0_fs = 4'b1100; req0_a = 64'd0; req0_b = 64'd0;
      cyc();                                   // EXEC
      req0_valid = 1'b0;
      cyc();                                   // RESP
      chk("fl_rv0",    {63'd0, resp0_valid}, 64'd1);
      chk("fl_f",      resp_f, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("fl_status", {60'd0, resp_status}, 64'h1);
      chk("fl_err",    {63'd0, resp_err}, 64'd0);
      resp0_ready = 1'b1;
      cyc();
      chk("fl_done_busy", {63'd0, busy}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the 64-bit ALU datapath. It accepts operation requests (`fs`, `a`, `b`) from two independent masters over valid/ready handshakes. It issues one operation at a time to the shared ALU, registers the ALU result and status flags, and returns them to the owning master over a valid/ready response channel. The block sits between the ALU instance and its clients; the ALU itself stays combinational and external.

## Interface
Parameters:
- `W`, 64: operand/result width; must match the ALU.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 operation accepted this cycle.
- `req0_fs`  in  4  requester 0 function select.
- `req0_a`  in  W  requester 0 operand a.
- `req0_b`  in  W  requester 0 operand b.
- `req1_valid`, `req1_ready`, `req1_fs`, `req1_a`, `req1_b`: same as above for requester 1.
- `resp0_valid`  out  1  result available for requester 0.
- `resp0_ready`  in  1  requester 0 takes result.
- `resp1_valid`  out  1  result available for requester 1.
- `resp1_ready`  in  1  requester 1 takes result.
- `resp_f`  out  W  registered result, shared by both response channels.
- `resp_status`  out  4  registered ALU flags {cout, z, v, n}.
- `resp_err`  out  1  operation rejected (illegal `fs`).
- `busy`  out  1  high whenever state is not IDLE.
- `alu_fs`  out  4  to ALU function select.
- `alu_a`  out  W  to ALU operand a.
- `alu_b`  out  W  to ALU operand b.
- `alu_f`  in  W  from ALU result.
- `alu_status`  in  4  from ALU status.

## Operation
- FSM states: IDLE, EXEC, RESP.
- Legal `fs` codes: 0000, 0001, 0010, 0110, 0111, 1100. Every other code is illegal.
- IDLE arbitration:
  - If only one `reqN_valid` is high, grant N.
  - If both are high, grant the requester selected by the priority pointer `prio` (reset 0).
  - `reqN_ready` = (state==IDLE) & grant==N. It is combinational and never high for both requesters.
- Acceptance edge (valid & ready):
  - Latch `fs`, `a`, `b` into operand registers and record `owner`=N.
  - Legal `fs`: go to EXEC.
  - Illegal `fs`: load `resp_f`=0, `resp_status`=0, `resp_err`=1, and go directly to RESP. The ALU is not used.
- EXEC (exactly 1 cycle):
  - `alu_fs`/`alu_a`/`alu_b` come from the operand registers.
  - Capture `alu_f` into `resp_f`, `alu_status` into `resp_status`, and clear `resp_err`.
  - Go to RESP.
- RESP:
  - `resp<owner>_valid`=1; the other channel's valid stays 0.
  - `resp_f`, `resp_status` and `resp_err` are held stable until the handshake completes.
  - On `resp<owner>_ready`=1: go to IDLE and set `prio` = ~owner. Fairness is therefore enforced after every completed operation.
- `alu_fs`/`alu_a`/`alu_b` are always driven from the operand registers and hold their last values in IDLE and RESP.
- The non-owner requester may hold `valid` indefinitely. It is only granted in IDLE.
- Requester inputs are sampled only on the acceptance edge. Changes at any other time have no effect.

## Timing
- Reset values: state=IDLE, `prio`=0, `owner`=0, operand registers=0, `resp_f`=0, `resp_status`=0, `resp_err`=0.
  - Outputs at reset: `busy`=0, both `reqN_ready`=0 when no valid, both `respN_valid`=0, `alu_*`=0.
- Latency, legal op: accept at edge T; EXEC during cycle T+1; `resp_valid` high from cycle T+2.
- Latency, illegal op: `resp_valid` high from cycle T+1.
- Throughput: one legal op per 3 cycles with `resp_ready` tied high. Back-to-back acceptance is possible in the cycle after the response handshake.
- Response ready asserted in the first RESP cycle: IDLE follows on the next cycle, and a new grant can occur in that IDLE cycle.
- Simultaneous valid and prio=1: requester 1 is granted; requester 0 is granted after requester 1's response completes.
- `rst` asserted in any state: the in-flight transaction is dropped with no response, and all registers return to their reset values on that edge.

## Test plan
- Single op: req0 fs=0010, a=5, b=7 -> req0_ready at T, resp0_valid at T+2, resp_f=12, resp_err=0, resp1_valid stays 0.
- Contention: req0 and req1 both valid from reset, both fs=0110, a=10, b=3 -> req0 served first (resp_f=7); req1 granted in the next IDLE; prio toggles 0→1→0.
- Illegal fs=1111 on req1 with a=9 -> resp1_valid at T+1, resp_f=0, resp_status=0, resp_err=1; `alu_*` never shows an EXEC for this op.
- Back-pressure: resp0_ready held low 5 cycles after resp0_valid -> resp_f/resp_status stable, busy=1, req1_ready=0 throughout despite req1_valid=1.
- Reset mid-EXEC: assert rst during the EXEC cycle -> next cycle all outputs at reset values, and no respN_valid pulse ever appears for the dropped op.
- Flag pass-through: fs=1100, a=0, b=0 -> resp_f=all ones, and resp_status equals the ALU status sampled in EXEC.
